pixel_compositor: RTL

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

---
 rtl/pixel_compositor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pixel_compositor.sv
// Three-stage sprite-over-background compositor feeding the palette mapper.
// Define SPRITE_FLIP_EN to build the latched horizontal sprite flip.
module pixel_compositor (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pixel_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank_n,
    input  logic        vs,
    input  logic [9:0]  spriteX,
    input  logic [9:0]  spriteY,
    input  logic [1:0]  spriteFrame,
    input  logic        facingLeft,
    input  logic [9:0]  bgScrollX,
    output logic [16:0] bg_addr,
    input  logic [5:0]  bg_data,
    output logic [11:0] spr_addr,
    input  logic [5:0]  spr_data,
    output logic [5:0]  colorValue,
    output logic        colorValid
);

    localparam logic [5:0] Transparent = 6'h3F;

    typedef enum logic {StActive, StVsync} state_e;

    state_e      state_q, state_d;
    logic        vs_q;
    logic [9:0]  sh_x_q, sh_x_d;
    logic [9:0]  sh_y_q, sh_y_d;
    logic [1:0]  sh_frame_q, sh_frame_d;
    logic [9:0]  sh_scroll_q, sh_scroll_d;
`ifdef SPRITE_FLIP_EN
    logic        sh_facing_q, sh_facing_d;
`endif

    logic [16:0] bg_addr_q, bg_addr_d;
    logic [11:0] spr_addr_q, spr_addr_d;
    logic        valid0_q, vis0_q, vis0_d, hit0_q, hit0_d;
    logic        valid1_q, vis1_q, hit1_q;
    logic [5:0]  color_value_q, color_value_d;
    logic        color_valid_q;

    logic        vs_fall;
    logic [9:0]  bgx, dx, dy;
    logic [4:0]  dxf;
    logic        hit_c;
    logic        unused_bits;

    assign vs_fall = vs_q & ~vs;

    // Shadows load only on the vs falling edge so a frame is drawn with one set of values.
    always_comb begin
        state_d     = state_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        sh_frame_d  = sh_frame_q;
        sh_scroll_d = sh_scroll_q;
`ifdef SPRITE_FLIP_EN
        sh_facing_d = sh_facing_q;
`endif
        unique case (state_q)
            StActive: begin
                if (vs_fall) begin
                    state_d     = StVsync;
                    sh_x_d      = spriteX;
                    sh_y_d      = spriteY;
                    sh_frame_d  = spriteFrame;
                    sh_scroll_d = bgScrollX;
`ifdef SPRITE_FLIP_EN
                    sh_facing_d = facingLeft;
`endif
                end
            end
            StVsync: begin
                if (vs) state_d = StActive;
            end
            default: state_d = StActive;
        endcase
    end

    // S0: address generation and sprite hit test against the shadowed frame values.
    always_comb begin
        bgx   = DrawX + sh_scroll_q;
        dx    = DrawX - sh_x_q;
        dy    = DrawY - sh_y_q;
        hit_c = (dx < 10'd32) && (dy < 10'd32);
`ifdef SPRITE_FLIP_EN
        dxf   = sh_facing_q ? (5'd31 - dx[4:0]) : dx[4:0];
`else
        dxf   = dx[4:0];
`endif
        bg_addr_d  = bg_addr_q;
        spr_addr_d = spr_addr_q;
        vis0_d     = vis0_q;
        hit0_d     = hit0_q;
        if (pixel_en) begin
            bg_addr_d  = {DrawY[8:1], bgx[9:1]};
            spr_addr_d = {sh_frame_q, dy[4:0], dxf};
            vis0_d     = blank_n;
            hit0_d     = hit_c;
        end
    end

`ifdef SPRITE_FLIP_EN
    assign unused_bits = bgx[0];
`else
    assign unused_bits = bgx[0] ^ facingLeft;
`endif

    // S2: ROM data for the pixel in S1 is valid now.
    always_comb begin
        color_value_d = color_value_q;
        if (valid1_q) begin
            if (!vis1_q) begin
                color_value_d = 6'h00;
            end else if (hit1_q && (spr_data != Transparent)) begin
                color_value_d = spr_data;
            end else begin
                color_value_d = bg_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StActive;
            vs_q          <= 1'b1;
            sh_x_q        <= '0;
            sh_y_q        <= '0;
            sh_frame_q    <= '0;
            sh_scroll_q   <= '0;
`ifdef SPRITE_FLIP_EN
            sh_facing_q   <= 1'b0;
`endif
            bg_addr_q     <= '0;
            spr_addr_q    <= '0;
            valid0_q      <= 1'b0;
            vis0_q        <= 1'b0;
            hit0_q        <= 1'b0;
            valid1_q      <= 1'b0;
            vis1_q        <= 1'b0;
            hit1_q        <= 1'b0;
            color_value_q <= '0;
            color_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs;
            sh_x_q        <= sh_x_d;
            sh_y_q        <= sh_y_d;
            sh_frame_q    <= sh_frame_d;
            sh_scroll_q   <= sh_scroll_d;
`ifdef SPRITE_FLIP_EN
            sh_facing_q   <= sh_facing_d;
`endif
            bg_addr_q     <= bg_addr_d;
            spr_addr_q    <= spr_addr_d;
            valid0_q      <= pixel_en;
            vis0_q        <= vis0_d;
            hit0_q        <= hit0_d;
            valid1_q      <= valid0_q;
            vis1_q        <= vis0_q;
            hit1_q        <= hit0_q;
            color_value_q <= color_value_d;
            color_valid_q <= valid1_q;
        end
    end

    assign bg_addr    = bg_addr_q;
    assign spr_addr   = spr_addr_q;
    assign colorValue = color_value_q;
    assign colorValid = color_valid_q;

endmodule
